// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding,
// default instruction-memory capacity and a counter-width helper.
package loader_pkg;

    // Default instruction-memory capacity in 32-bit words.
    localparam int MAX_WORDS_DEFAULT = 1024;

    // Loader FSM states.
    typedef enum logic [2:0] {
        LEN,
        DATA,
        FLUSH,
        DONE,
        ERR
    } state_e;

    // Bits needed to hold the values 0..max_words inclusive without wrapping.
    function automatic int cnt_width(input int max_words);
        return $clog2(max_words + 1);
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// Big-endian byte-to-word assembler. Shifts accepted bytes into a 32-bit
// register and flags the cycle in which the 4th byte of a word arrives.
// The flagged word is presented combinationally so the caller can register
// it on the same edge that accepts the final byte.
module byte_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [31:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;

    // Next-state: shift in on an accepted byte; the 2-bit count wraps 3->0.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (byte_en_i) begin
            shift_d = {shift_q[23:0], byte_i};
            cnt_d   = cnt_q + 2'd1;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // The first byte of a word ends up in bits 31:24.
    assign word_o       = shift_d;
    assign word_valid_o = byte_en_i && (cnt_q == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Program loader: receives a big-endian byte stream (word count N, then N
// instruction words), writes the words to instruction memory at 4*k, and
// holds the CPU until the load finishes. Oversized headers land in ERR.
module prog_loader
    import loader_pkg::*;
#(
    parameter int MAX_WORDS = MAX_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    // Wide enough to hold N = MAX_WORDS and the post-increment of k.
    localparam int CW = cnt_width(MAX_WORDS);

    state_e        state_q, state_d;
    logic          live_q;
    logic [CW-1:0] n_q, n_d;
    logic [CW-1:0] k_q, k_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;

    logic          accept;
    logic          word_valid;
    logic [31:0]   word;

    // live_q keeps in_ready low until the first edge after reset is released.
    assign in_ready = live_q && ((state_q == LEN) || (state_q == DATA));
    assign accept   = in_valid && in_ready;

    byte_assembler u_asm (
        .clk          (clk),
        .reset        (reset),
        .byte_en_i    (accept),
        .byte_i       (in_data),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    // Next-state and datapath: header decode, write scheduling, flush.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            LEN: begin
                if (word_valid) begin
                    n_d = word[CW-1:0];
                    k_d = '0;
                    if (word == 32'd0)
                        state_d = DONE;
                    else if (word > 32'(MAX_WORDS))
                        state_d = ERR;
                    else
                        state_d = DATA;
                end
            end
            DATA: begin
                if (word_valid) begin
                    we_d    = 1'b1;
                    wdata_d = word;
                    addr_d  = 32'({k_q, 2'b00});
                    k_d     = k_q + CW'(1);
                    // The last word's pulse is carried by the FLUSH cycle.
                    if (k_q == n_q - CW'(1))
                        state_d = FLUSH;
                end
            end
            FLUSH:   state_d = DONE;
            default: state_d = state_q;
        endcase
    end

    // State and output registers; reset also drops any pending write pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= LEN;
            live_q  <= 1'b0;
            n_q     <= '0;
            k_q     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            n_q     <= n_d;
            k_q     <= k_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = (state_q != DONE);
    assign done       = (state_q == DONE);
    assign error      = (state_q == ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of load scenarios, randomized loads and
// hand-written reset corner cases, checked against a stream-parsing model.
module tb_prog_loader;

    localparam int MAXW = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, imem_we, cpu_hold, done, error;
    logic [31:0] imem_addr, imem_wdata;

    prog_loader #(.MAX_WORDS(MAXW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  stream_q[$];
    logic [31:0] fixed_w[$];
    logic [31:0] got_a[$], got_d[$], exp_a[$], exp_d[$];
    int last_we_cyc = -1, first_done_cyc = -1, first_free_cyc = -1;
    int last_acc_cyc = -1, ready_drops = 0;

    // Passive monitor: every write and the first cycles of done / released hold.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            got_a.push_back(imem_addr);
            got_d.push_back(imem_wdata);
            last_we_cyc = cyc;
        end
        if (done === 1'b1 && first_done_cyc < 0) first_done_cyc = cyc;
        if (cpu_hold === 1'b0 && first_free_cyc < 0) first_free_cyc = cyc;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: parse the byte stream as header + big-endian words.
    function automatic void model();
        logic [31:0] n;
        exp_a.delete();
        exp_d.delete();
        n = {stream_q[0], stream_q[1], stream_q[2], stream_q[3]};
        if (n <= 32'(MAXW)) begin
            for (int k = 0; k < int'(n); k++) begin
                exp_a.push_back(32'(4 * k));
                exp_d.push_back({stream_q[4+4*k], stream_q[5+4*k],
                                 stream_q[6+4*k], stream_q[7+4*k]});
            end
        end
    endfunction

    task automatic build(input logic [31:0] n);
        int nw;
        logic [31:0] w;
        stream_q.delete();
        for (int i = 3; i >= 0; i--) stream_q.push_back(n[8*i +: 8]);
        nw = (n <= 32'(MAXW)) ? int'(n) : 0;
        for (int k = 0; k < nw; k++) begin
            w = (k < fixed_w.size()) ? fixed_w[k] : $urandom;
            for (int i = 3; i >= 0; i--) stream_q.push_back(w[8*i +: 8]);
        end
    endtask

    task automatic do_reset(input bit check);
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        if (check) begin
            chk("rst_in_ready", in_ready, 0);
            chk("rst_imem_we", imem_we, 0);
            chk("rst_imem_addr", imem_addr, 0);
            chk("rst_imem_wdata", imem_wdata, 0);
            chk("rst_cpu_hold", cpu_hold, 1);
            chk("rst_done", done, 0);
            chk("rst_error", error, 0);
        end
        reset = 1'b1;
        if (check) chk("ready_before_first_edge", in_ready, 0);
        @(negedge clk);
        if (check) chk("ready_after_release", in_ready, 1);
        got_a.delete();
        got_d.delete();
        last_we_cyc = -1;
        first_done_cyc = -1;
        first_free_cyc = -1;
    endtask

    // Offer every byte of stream_q; gap<0 means random 0..2 idle cycles.
    task automatic drive_stream(input int gap);
        int idx = 0, gcnt = 0, budget = 20000, cur;
        bit rdy;
        ready_drops = 0;
        while (idx < stream_q.size() && budget > 0) begin
            budget--;
            @(negedge clk);
            if (gcnt > 0) begin
                in_valid = 1'b0;
                in_data = 8'($urandom);
                gcnt--;
            end else begin
                in_valid = 1'b1;
                in_data = stream_q[idx];
            end
            rdy = in_ready;
            cur = cyc;
            if (!rdy) ready_drops++;
            @(posedge clk);
            if (in_valid && rdy) begin
                idx++;
                last_acc_cyc = cur;
                gcnt = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            end
        end
        chk("bytes_accepted", idx, stream_q.size());
    endtask

    task automatic wait_terminal(input string nm);
        int w = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (!(done || error) && w < 8) begin
            @(negedge clk);
            w++;
        end
        chk({nm, "_terminal_reached"}, 32'(done || error), 1);
    endtask

    task automatic run_load(input string nm, input logic [31:0] n, input int gap,
                            input bit x_done, input bit x_err);
        int late = 0;
        build(n);
        model();
        do_reset(1);
        drive_stream(gap);
        wait_terminal(nm);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data = 8'($urandom);
            if (in_ready) late++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk({nm, "_done"}, 32'(done), 32'(x_done));
        chk({nm, "_error"}, 32'(error), 32'(x_err));
        chk({nm, "_cpu_hold"}, 32'(cpu_hold), 32'(!x_done));
        chk({nm, "_ready_after_end"}, late, 0);
        chk({nm, "_ready_drops"}, ready_drops, 0);
        chk({nm, "_n_writes"}, got_a.size(), exp_a.size());
        for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
            chk({nm, "_addr"}, got_a[i], exp_a[i]);
            chk({nm, "_data"}, got_d[i], exp_d[i]);
        end
        if (n == 32'(MAXW) && got_a.size() > 0) chk({nm, "_final_addr"}, got_a[$], 32'hFFC);
        if (x_done) begin
            if (exp_a.size() > 0) begin
                chk({nm, "_last_pulse_cyc"}, last_we_cyc, last_acc_cyc + 1);
                chk({nm, "_done_cyc"}, first_done_cyc, last_we_cyc + 1);
            end else begin
                chk({nm, "_done_cyc"}, first_done_cyc, last_acc_cyc + 1);
            end
            chk({nm, "_hold_fall_cyc"}, first_free_cyc, first_done_cyc);
        end else begin
            chk({nm, "_hold_never_fell"}, first_free_cyc, -1);
        end
    endtask

    // Deliver a fresh 1-word load and expect exactly one write of w to addr 0.
    task automatic one_word_after(input string nm, input logic [31:0] w);
        fixed_w = '{w};
        build(1);
        drive_stream(0);
        wait_terminal(nm);
        chk({nm, "_done"}, 32'(done), 1);
        chk({nm, "_n_writes"}, got_a.size(), 1);
        if (got_a.size() > 0) begin
            chk({nm, "_addr"}, got_a[0], 0);
            chk({nm, "_data"}, got_d[0], w);
        end
    endtask

    typedef struct {
        string       nm;
        logic [31:0] n;
        int          gap;
        bit          x_done;
        bit          x_err;
        bit          fixed;
    } vec_t;

    vec_t vt[7];

    initial begin
        logic [7:0] last_b;

        vt[0] = '{"two_word",  32'd2,          0,  1'b1, 1'b0, 1'b1};
        vt[1] = '{"zero_len",  32'd0,          0,  1'b1, 1'b0, 1'b0};
        vt[2] = '{"over_len",  32'h0000_0401,  0,  1'b0, 1'b1, 1'b0};
        vt[3] = '{"gapped",    32'd1,          3,  1'b1, 1'b0, 1'b0};
        vt[4] = '{"max_len",   32'd1024,       0,  1'b1, 1'b0, 1'b0};
        vt[5] = '{"huge_len",  32'hFFFF_FFFF,  0,  1'b0, 1'b1, 1'b0};
        vt[6] = '{"rand_gaps", 32'd5,          -1, 1'b1, 1'b0, 1'b0};

        for (int v = 0; v < 7; v++) begin
            if (vt[v].fixed) fixed_w = '{32'h2008_0005, 32'h0000_0000};
            else fixed_w.delete();
            run_load(vt[v].nm, vt[v].n, vt[v].gap, vt[v].x_done, vt[v].x_err);
        end

        fixed_w.delete();
        for (int r = 0; r < 6; r++)
            run_load("rand_ok", 32'($urandom_range(1, 8)), -1, 1'b1, 1'b0);
        for (int r = 0; r < 2; r++)
            run_load("rand_err", 32'($urandom_range(MAXW + 1, 200000)), 0, 1'b0, 1'b1);

        // Reset after two data bytes: partial word must be discarded.
        fixed_w.delete();
        do_reset(0);
        build(1);
        while (stream_q.size() > 6) void'(stream_q.pop_back());
        drive_stream(0);
        do_reset(1);
        chk("midload_rst_no_write", got_a.size(), 0);
        one_word_after("after_midload_rst", 32'h1234_5678);

        // Reset coincides with the last byte of a word: its pulse must not appear.
        fixed_w.delete();
        do_reset(0);
        build(2);
        while (stream_q.size() > 7) void'(stream_q.pop_back());
        fixed_w.delete();
        last_b = 8'hA5;
        drive_stream(0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data = last_b;
        reset = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst_suppresses_we", imem_we, 0);
        chk("rst_suppress_ready", in_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_suppress_ready_back", in_ready, 1);
        chk("rst_suppress_no_write", got_a.size(), 0);
        chk("rst_suppress_hold", cpu_hold, 1);
        one_word_after("after_pulse_rst", 32'hCAFE_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have parameter MAX_WORDS, default 1024, the instruction-memory capacity in 32-bit words.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit; reset is synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit, meaning a byte is offered on in_data.
REQ-005 The block SHALL have port in_data, input, 8 bits, the program byte stream.
REQ-006 The block SHALL have port in_ready, output, 1 bit, meaning the loader accepts a byte this cycle.
REQ-007 The block SHALL have port imem_we, output, 1 bit, the instruction-memory write strobe.
REQ-008 The block SHALL have port imem_addr, output, 32 bits, the byte address of the write, always word-aligned.
REQ-009 The block SHALL have port imem_wdata, output, 32 bits, the instruction word being written.
REQ-010 The block SHALL have port cpu_hold, output, 1 bit, which holds the processor PC in reset while high.
REQ-011 The block SHALL have port done, output, 1 bit, meaning the load completed successfully.
REQ-012 The block SHALL have port error, output, 1 bit, meaning the length header exceeded MAX_WORDS.

Function
REQ-013 A byte SHALL be accepted only in a cycle where in_valid and in_ready are both 1; in_data is ignored otherwise.
REQ-014 The stream format SHALL be a 4-byte word count N followed by N 4-byte instruction words, all big-endian (first byte goes to bits 31:24).
REQ-015 The state machine SHALL have exactly the states LEN, DATA, FLUSH, DONE and ERR.
REQ-016 In LEN, the loader SHALL collect 4 bytes into N; on the 4th byte it goes to DONE if N=0, to ERR if N>MAX_WORDS, and to DATA otherwise.
REQ-017 In DATA, on accepting the 4th byte of word k (k counted from 0), the loader SHALL register imem_wdata=word and imem_addr=4*k, and pulse imem_we for exactly the next cycle.
REQ-018 The loader SHALL move DATA->FLUSH on the 4th byte of word N-1; FLUSH lasts one cycle, carries that word's imem_we pulse, and then goes to DONE.
REQ-019 in_ready SHALL be 1 in LEN and DATA, including the write-pulse cycle, so throughput is one byte per cycle; in_ready SHALL be 0 in FLUSH, DONE and ERR.
REQ-020 cpu_hold SHALL be 1 in every state except DONE, so cpu_hold falls in the cycle after the last imem_we pulse.
REQ-021 done SHALL be 1 only in DONE; error SHALL be 1 only in ERR.
REQ-022 DONE and ERR SHALL be terminal; only reset leaves them, and further input bytes are not accepted.
REQ-023 The word counter SHALL be wide enough to count to MAX_WORDS with no wrap; N=MAX_WORDS is legal and its last write goes to 4*(MAX_WORDS-1).
REQ-024 Gaps in in_valid SHALL stall assembly without losing any partially assembled bytes.

Reset
REQ-025 While reset=0 at a clock edge, the block SHALL enter LEN, clear the byte and word counters, and drive in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0 and error=0.
REQ-026 A reset asserted mid-load SHALL discard any partial word, suppress any pending imem_we pulse, and restart at the length header.
REQ-027 in_ready SHALL first become 1 in the first cycle after reset is released.

Structure
REQ-028 The state encoding and the default value of MAX_WORDS SHALL reside in the shared package loader_pkg.
REQ-029 Byte assembly SHALL be a single sub-module, byte_assembler, containing a 32-bit shift register and a 2-bit byte counter with a word_valid output; it is reused for both LEN and DATA.

Verification
REQ-030 The bench SHALL drive bytes 00 00 00 02, 20 08 00 05, 00 00 00 00 back-to-back and check: imem_we pulses writing 0x20080005 to addr 0 and then 0x00000000 to addr 4; cpu_hold falls and done rises the cycle after the second pulse.
REQ-031 The bench SHALL drive header 00 00 00 00 and check: DONE one cycle after the 4th byte, no imem_we pulse, in_ready=0 thereafter.
REQ-032 The bench SHALL drive header 00 00 04 01 with MAX_WORDS=1024 and check: error=1, cpu_hold stays 1, in_ready=0, no writes occur.
REQ-033 The bench SHALL send a 1-word load with in_valid low for 3 cycles between every byte and check that the correct word is written and in_ready stays 1 through the gaps.
REQ-034 The bench SHALL assert reset after 2 data bytes, then send a full 1-word stream and check: no stale write, the first write goes to addr 0 with the new data only.
REQ-035 The bench SHALL run an N=1024 load and check that the final write address is 0xFFC and that done asserts.
